// File: rtl/sequence_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: default sizing,
// length-field width helper and the FSM state encoding.
package sequence_tx_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 4;
  localparam int GAP_DEF   = 1;
  localparam int LEN_W     = $clog2(PAT_W_DEF + 1);

  // Width of a length field able to hold 0..pat_w.
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/sequence_tx_if.sv
// Request/serial-output bundle between a pattern requester and sequence_tx.
interface sequence_tx_if
  import sequence_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int LW = len_width(PAT_W);

  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat_in;
  logic [LW-1:0]    pat_len;
  logic [CNT_W-1:0] rep_cnt;
  logic             data;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pat_in, pat_len, rep_cnt,
    input  data, valid, busy, done
  );

  modport slave (
    input  start, abort, pat_in, pat_len, rep_cnt,
    output data, valid, busy, done
  );

endinterface

// File: rtl/sequence_tx_shifter.sv
// Pattern store and bit-index down-counter. bit_out_o is the bit emitted on the
// current edge when load_i/shift_i is high; last_bit_o flags the presented bit as final.
module sequence_tx_shifter
  import sequence_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LW    = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LW-1:0]    len_i,
  output logic             bit_out_o,
  output logic             last_bit_o
);

  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] sh_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    cnt_q;
  logic [PAT_W-1:0] aligned;

  // Left-align so the first bit to send always sits at the MSB.
  always_comb aligned = pat_i << (PAT_W - int'(len_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= '0;
      sh_q  <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      pat_q <= aligned;
      sh_q  <= aligned << 1;
      len_q <= len_i;
      cnt_q <= len_i - LW'(1);
    end else if (shift_i) begin
      if (cnt_q == '0) begin
        sh_q  <= pat_q << 1;
        cnt_q <= len_q - LW'(1);
      end else begin
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q - LW'(1);
      end
    end
  end

  always_comb begin
    bit_out_o = sh_q[PAT_W-1];
    if (load_i) begin
      bit_out_o = aligned[PAT_W-1];
    end else if (cnt_q == '0) begin
      bit_out_o = pat_q[PAT_W-1];
    end
  end

  assign last_bit_o = (cnt_q == '0);

endmodule

// File: rtl/sequence_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated
// rep_cnt times with GAP idle bits between repetitions.
module sequence_tx
  import sequence_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sequence_tx_if.slave  bus
);

  localparam int LW = len_width(PAT_W);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, shift, bit_out, last_bit, accept;

  sequence_tx_shifter #(.PAT_W(PAT_W), .LW(LW)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .shift_i    (shift),
    .pat_i      (bus.pat_in),
    .len_i      (bus.pat_len),
    .bit_out_o  (bit_out),
    .last_bit_o (last_bit)
  );

  assign accept = bus.start && !bus.abort && (bus.pat_len != '0) &&
                  (int'(bus.pat_len) <= PAT_W) && (bus.rep_cnt != '0);

  // Outputs are computed for the cycle being entered, so the first bit
  // appears on the cycle right after the accepting edge.
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    data_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          rep_d   = bus.rep_cnt;
          state_d = ST_SEND;
          data_d  = bit_out;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_SEND: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (last_bit && rep_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (last_bit && GAP > 0) begin
          rep_d   = rep_q - CNT_W'(1);
          gap_d   = GW'(GAP - 1);
          state_d = ST_GAP;
          busy_d  = 1'b1;
        end else begin
          if (last_bit) begin
            rep_d = rep_q - CNT_W'(1);
          end
          shift   = 1'b1;
          data_d  = bit_out;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          state_d = ST_SEND;
          shift   = 1'b1;
          data_d  = bit_out;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gap_d  = gap_q - GW'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rep_q   <= '0;
      gap_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_sequence_tx.sv
// Directed bench for sequence_tx: accepted starts push the expected per-cycle
// {data,valid,busy,done} sequence into a queue that is popped every cycle.
module tb_sequence_tx;
  import sequence_tx_pkg::*;

  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int GAP   = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sequence_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  sequence_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc_n = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur_exp = 4'b0000;
  string      tname = "reset";

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed(d,v,b,dn)=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_seq(input logic [PAT_W-1:0] pat, input int len, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = len - 1; i >= 0; i--) exp_q.push_back({pat[i], 3'b110});
      if (r < reps - 1) begin
        for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
      end
    end
    exp_q.push_back(4'b0001);
  endtask

  // One clock: update the scoreboard from the inputs about to be sampled, then compare.
  task automatic cyc();
    int len;
    len = int'(bus.pat_len);
    if (!rst) begin
      exp_q.delete();
    end else if (cur_exp[1] && bus.abort) begin
      $display("TXN %s abort", tname);
      exp_q.delete();
    end else if (!cur_exp[1] && bus.start) begin
      if (!bus.abort && len >= 1 && len <= PAT_W && bus.rep_cnt != '0) begin
        $display("TXN %s start pat=%b len=%0d reps=%0d", tname, bus.pat_in, len, bus.rep_cnt);
        push_seq(bus.pat_in, len, int'(bus.rep_cnt));
      end else begin
        $display("TXN %s start dropped len=%0d reps=%0d abort=%0d", tname, len, bus.rep_cnt, bus.abort);
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
    else cur_exp = 4'b0000;
    cyc_n++;
    busy_cnt += int'(bus.busy);
    done_cnt += int'(bus.done);
    check($sformatf("%s@%0d", tname, cyc_n), {bus.data, bus.valid, bus.busy, bus.done}, cur_exp);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic set_req(input logic [PAT_W-1:0] pat, input int len, input int reps);
    bus.pat_in  = pat;
    bus.pat_len = 4'(len);
    bus.rep_cnt = 4'(reps);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_req('0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset", {bus.data, bus.valid, bus.busy, bus.done}, 4'b0000);
    rst = 1'b1;
    run(2);

    tname = "single";
    set_req(8'b0001_0111, 5, 1);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    run(6);

    tname = "rep2";
    set_req(8'b0001_0111, 5, 2);
    busy_cnt = 0; done_cnt = 0;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    run(12);
    check_int("rep2_busy_cycles", busy_cnt, 11);
    check_int("rep2_done_pulses", done_cnt, 1);

    tname = "abort";
    set_req(8'b0001_0111, 5, 2);
    done_cnt = 0;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    run(2);
    bus.abort = 1'b1; cyc(); bus.abort = 1'b0;
    run(3);
    check_int("abort_no_done", done_cnt, 0);
    tname = "after_abort";
    set_req(8'hA5, 8, 1);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    run(9);

    tname = "invalid";
    done_cnt = 0;
    set_req(8'hFF, 0, 1);
    bus.start = 1'b1; cyc(); bus.start = 1'b0; cyc();
    set_req(8'hFF, PAT_W + 1, 1);
    bus.start = 1'b1; cyc(); bus.start = 1'b0; cyc();
    set_req(8'hFF, 5, 0);
    bus.start = 1'b1; cyc(); bus.start = 1'b0; cyc();
    set_req(8'hFF, 5, 1);
    bus.start = 1'b1; bus.abort = 1'b1; cyc(); bus.start = 1'b0; cyc();
    cyc(); bus.abort = 1'b0;
    check_int("invalid_no_done", done_cnt, 0);

    tname = "busy_start";
    set_req(8'b0001_0111, 5, 1);
    bus.start = 1'b1; cyc();
    set_req(8'b0000_0110, 3, 2);
    cyc(); bus.start = 1'b0;
    run(4);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    run(8);

    tname = "bounds";
    set_req(8'b1100_1010, 8, 3);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    run(27);
    set_req(8'h01, 1, 2);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    run(4);

    tname = "async_rst";
    set_req(8'b0001_0111, 5, 2);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    cyc();
    #2 rst = 1'b0;
    #1;
    check("async_rst_immediate", {bus.data, bus.valid, bus.busy, bus.done}, 4'b0000);
    exp_q.delete();
    cur_exp = 4'b0000;
    run(2);
    rst = 1'b1;
    cyc();
    tname = "after_rst";
    set_req(8'b0000_1101, 4, 1);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
